// File: rtl/dsp48a1_ctrl_pkg.sv
// Shared definitions for the DSP48A1 MAC control logic: sequencer states,
// OPMODE encodings and the OPMODE decode helper.
package dsp48a1_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // X=M, Z=0 loads P with the product; X=M, Z=P accumulates into P
  localparam logic [7:0] OPMODE_FIRST = 8'h01;
  localparam logic [7:0] OPMODE_ACC   = 8'h09;
  localparam logic [7:0] OPMODE_NONE  = 8'h00;

  function automatic logic [7:0] opmode_for(input logic v, input logic first);
    logic [7:0] op;
    if (!v) begin
      op = OPMODE_NONE;
    end else if (first) begin
      op = OPMODE_FIRST;
    end else begin
      op = OPMODE_ACC;
    end
    return op;
  endfunction

endpackage

// File: rtl/mac_token_pipe.sv
// Two-stage valid/first token shift register that tracks each accepted
// operand pair through the slice M and P register stages.
module mac_token_pipe
  import dsp48a1_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_first,
  output logic v0,
  output logic v1,
  output logic f1,
  output logic empty
);

  logic v0_r;
  logic f0_r;
  logic v1_r;
  logic f1_r;

  // Shift tokens one stage per cycle; bubbles travel as v=0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v0_r <= 1'b0;
      f0_r <= 1'b0;
      v1_r <= 1'b0;
      f1_r <= 1'b0;
    end else begin
      v0_r <= in_valid;
      f0_r <= in_valid & in_first;
      v1_r <= v0_r;
      f1_r <= v0_r & f0_r;
    end
  end

  assign v0 = v0_r;
  assign v1 = v1_r;
  assign f1 = f1_r;
  // A token in stage 1 is written into P at this edge, so the pipeline
  // is drained after the edge when nothing sits behind it.
  assign empty = ~v0_r & ~in_valid;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Dot-product sequencer for a DSP48A1-style MAC slice: operand handshake,
// slice clock enables, OPMODE selection and result handshake.
module dsp_mac_sequencer
  import dsp48a1_ctrl_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             op_valid,
  output logic             op_ready,
  output logic             ce_a,
  output logic             ce_b,
  output logic             ce_m,
  output logic             ce_p,
  output logic [7:0]       opmode,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ack
);

  localparam logic [LEN_W-1:0] REM_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] REM_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_e           state_r;
  state_e           state_nxt_s;
  logic [LEN_W-1:0] rem_r;
  logic [LEN_W-1:0] rem_nxt_s;
  logic             first_r;
  logic             first_nxt_s;
  logic             accept_s;
  logic             v0_s;
  logic             v1_s;
  logic             f1_s;
  logic             empty_s;

  assign accept_s = op_valid & (state_r == FEED);

  // Next-state, remaining-count and first-operand decode
  always_comb begin
    state_nxt_s = state_r;
    rem_nxt_s   = rem_r;
    first_nxt_s = first_r;
    case (state_r)
      IDLE: begin
        if (start && (len != REM_ZERO)) begin
          state_nxt_s = FEED;
          rem_nxt_s   = len;
          first_nxt_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FEED: begin
        if (accept_s) begin
          rem_nxt_s   = rem_r - REM_ONE;
          first_nxt_s = 1'b0;
          if (rem_r == REM_ONE) begin
            state_nxt_s = DRAIN;
          end else begin
            state_nxt_s = FEED;
          end
        end else begin
          state_nxt_s = FEED;
        end
      end
      DRAIN: begin
        if (empty_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      HOLD: begin
        // start is deliberately not looked at here, even alongside res_ack
        if (res_ack) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        rem_nxt_s   = REM_ZERO;
        first_nxt_s = 1'b0;
      end
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      rem_r   <= REM_ZERO;
      first_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      rem_r   <= rem_nxt_s;
      first_r <= first_nxt_s;
    end
  end

  mac_token_pipe u_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_valid (accept_s),
    .in_first (first_r),
    .v0       (v0_s),
    .v1       (v1_s),
    .f1       (f1_s),
    .empty    (empty_s)
  );

  // Every output decodes from reset-cleared registers, so all drop to 0 with reset
  assign op_ready  = (state_r == FEED);
  assign ce_a      = accept_s;
  assign ce_b      = accept_s;
  assign ce_m      = v0_s;
  assign ce_p      = v1_s;
  assign opmode    = opmode_for(v1_s, f1_s);
  assign busy      = (state_r != IDLE);
  assign res_valid = (state_r == HOLD);

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Self-checking bench for dsp_mac_sequencer: per-cycle strobe timing checks
// plus an OPMODE scoreboard filled as operands are offered.
module tb_dsp_mac_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] len;
  logic       op_valid;
  logic       op_ready;
  logic       ce_a;
  logic       ce_b;
  logic       ce_m;
  logic       ce_p;
  logic [7:0] opmode;
  logic       busy;
  logic       res_valid;
  logic       res_ack;

  int         n_checks;
  int         n_errors;
  logic [7:0] exp_q[$];
  logic       acc_d1;
  logic       acc_d2;

  dsp_mac_sequencer #(.LEN_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .ce_a      (ce_a),
    .ce_b      (ce_b),
    .ce_m      (ce_m),
    .ce_p      (ce_p),
    .opmode    (opmode),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ack   (res_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_op_ready"}, {7'd0, op_ready}, 8'h00);
    check({tag, "_ce_ab"}, {6'd0, ce_a, ce_b}, 8'h00);
    check({tag, "_ce_mp"}, {6'd0, ce_m, ce_p}, 8'h00);
    check({tag, "_opmode"}, opmode, 8'h00);
    check({tag, "_busy_rv"}, {6'd0, busy, res_valid}, 8'h00);
  endtask

  // One clock cycle: drive at posedge+1, sample at negedge, return at next posedge+1.
  // e_acc means the bench expects this cycle to be an accepted operand.
  task automatic step(input logic st, input logic [7:0] ln, input logic ov,
                      input logic ack, input logic e_acc, input logic e_rdy,
                      input logic e_busy, input logic e_rv);
    logic [7:0] want;
    start    = st;
    len      = ln;
    op_valid = ov;
    res_ack  = ack;
    @(negedge clk);
    check("op_ready", {7'd0, op_ready}, {7'd0, e_rdy});
    check("busy", {7'd0, busy}, {7'd0, e_busy});
    check("res_valid", {7'd0, res_valid}, {7'd0, e_rv});
    check("ce_a", {7'd0, ce_a}, {7'd0, e_acc});
    check("ce_b", {7'd0, ce_b}, {7'd0, e_acc});
    check("ce_m", {7'd0, ce_m}, {7'd0, acc_d1});
    check("ce_p", {7'd0, ce_p}, {7'd0, acc_d2});
    if (ce_p) begin
      if (exp_q.size() == 0) begin
        check("ce_p_stray", {7'd0, ce_p}, 8'h00);
      end else begin
        want = exp_q.pop_front();
        check("opmode_sb", opmode, want);
      end
    end else begin
      check("opmode_idle", opmode, 8'h00);
    end
    acc_d2 = acc_d1;
    acc_d1 = e_acc;
    @(posedge clk);
    #1;
  endtask

  // Full job: optional one-cycle op_valid gap before operand index gap_at.
  task automatic run_job(input logic [7:0] n, input int gap_at);
    step(1'b1, n, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < int'(n); i++) begin
      if (i == gap_at) begin
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      end
      exp_q.push_back((i == 0) ? 8'h01 : 8'h09);
      step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    end
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // third cycle after the last accept: result must be presented
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic ack_job();
    step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sb_drained", 8'(exp_q.size()), 8'h00);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    acc_d1   = 1'b0;
    acc_d2   = 1'b0;
    reset    = 1'b1;
    start    = 1'b0;
    len      = 8'd0;
    op_valid = 1'b0;
    res_ack  = 1'b0;
    #1;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // single operand: ce_m, ce_p+FIRST, result at 3 cycles
    run_job(8'd1, -1);
    ack_job();

    // four back-to-back operands
    run_job(8'd4, -1);
    ack_job();

    // bubble between first and second operand
    run_job(8'd3, 1);
    ack_job();

    // result held while start pulses are ignored, start alongside ack ignored
    run_job(8'd2, -1);
    for (int i = 0; i < 5; i++) begin
      step(i[0], 8'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    step(1'b1, 8'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_job(8'd2, -1);
    ack_job();

    // reset in FEED after 2 of 5 accepts
    step(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'h01);
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(8'h09);
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    op_valid = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("midjob_reset");
    @(posedge clk);
    #1;
    reset    = 1'b0;
    op_valid = 1'b0;
    exp_q.delete();
    acc_d1 = 1'b0;
    acc_d2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    run_job(8'd1, -1);
    ack_job();

    // zero-length start is ignored
    step(1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
